// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 signed max-pool over one raster-ordered plane.
//   The maxima of horizontal pairs in even rows go into a half-width line
//   buffer. Odd rows combine their own pair maxima with the buffered values.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     in_valid/in_ready/in_data     input pixel stream
//     in_last                       last input pixel of the plane
//     out_valid/out_ready/out_data  pooled pixel stream
//     out_last                      last pooled pixel of the plane
//     err_last                      sticky in_last / position mismatch flag
module maxpool2x2_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = (IMG_W > 2) ? $clog2(IMG_W/2) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] linebuf [IMG_W/2];

  logic              accept, col_end, row_end, plane_end, load;
  logic [AW-1:0]     lb_idx;
  logic [DATA_W-1:0] lb_rd, hmax, pooled;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign col_end   = (col == CW'(IMG_W-1));
  assign row_end   = (row == RW'(IMG_H-1));
  assign plane_end = col_end && row_end;
  // Pixels 2k and 2k+1 of a row share line buffer slot k.
  assign lb_idx    = AW'(col >> 1);
  assign lb_rd     = linebuf[lb_idx];
  assign hmax      = ($signed(hold) > $signed(in_data)) ? hold : in_data;
  assign pooled    = ($signed(lb_rd) > $signed(hmax)) ? lb_rd : hmax;
  assign load      = accept && col[0] && row[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (!col[0]) hold <= in_data;
        // Flag only; the counters keep tracking the internal position.
        if (in_last != plane_end) err_last <= 1'b1;
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // A fresh pooled value takes priority over draining the register.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= pooled;
        out_last  <= plane_end;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // The line buffer is not reset: every slot is written in an even row
  // before the odd row that follows reads it.
  always_ff @(posedge clk) begin
    if (!rst && accept && col[0] && !row[0]) linebuf[lb_idx] <= hmax;
  end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;
  localparam int W = 4, H = 4, N = W*H;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, err_last;
  logic [15:0] in_data, out_data;
  logic rdy_cmd, rand_mode, rnd;

  int tests = 0, fails = 0, last_cnt = 0;
  logic [16:0] exq [$];
  logic [15:0] pl [N];

  always #5 clk = ~clk;
  assign out_ready = rand_mode ? rnd : rdy_cmd;

  maxpool2x2_stream #(.DATA_W(16), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_last(err_last)
  );

  initial rnd = 1'b1;
  always begin
    @(posedge clk); #1;
    rnd = 1'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Max of the four input pixels of pooled output (r, c).
  function automatic logic [15:0] pool(input int r, input int c);
    logic signed [15:0] v [4];
    logic signed [15:0] m;
    v[0] = pl[2*r*W + 2*c];     v[1] = pl[2*r*W + 2*c + 1];
    v[2] = pl[(2*r+1)*W + 2*c]; v[3] = pl[(2*r+1)*W + 2*c + 1];
    m = v[0];
    for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
    return m;
  endfunction

  task automatic expect_plane();
    for (int r = 0; r < H/2; r++)
      for (int c = 0; c < W/2; c++)
        exq.push_back({(r == H/2-1 && c == W/2-1), pool(r, c)});
  endtask

  task automatic rand_plane();
    for (int i = 0; i < N; i++) pl[i] = 16'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic l);
    logic acc, done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) check("send_timeout", {31'b0, in_ready}, 1);
  endtask

  task automatic send_beats(input int from, input int upto, input int last_at);
    for (int i = from; i < upto; i++) begin
      send(pl[i], i == last_at);
      if ((i / W) % 2 == 1 && (i % W) % 2 == 1) begin
        check("lat_valid", {31'b0, out_valid}, 1);
        check("lat_data", 32'(out_data), 32'(pool((i / W) / 2, (i % W) / 2)));
        check("lat_last", {31'b0, out_last}, {31'b0, i == N-1});
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exq.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_empty", exq.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exq.size() == 0) begin
        check("unexpected_out", {31'b0, out_valid}, 0);
      end else begin
        e = exq.pop_front();
        check("out_data", 32'(out_data), 32'(e[15:0]));
        check("out_last", {31'b0, out_last}, {31'b0, e[16]});
        if (out_last) last_cnt++;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h7fff; in_last = 1'b0;
    rdy_cmd = 1'b1; rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_err_last", {31'b0, err_last}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    rst = 1'b0; in_valid = 1'b0;

    // Basic 4x4 plane: expected pooled outputs 5, 7, 10, 12
    pl = '{16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd0, 16'd7, 16'd6,
           16'd9, 16'd8, 16'd1, 16'd1, 16'd2, 16'd10, 16'd0, 16'd12};
    expect_plane();
    send_beats(0, N, N-1);
    drain();
    check("basic_last_cnt", last_cnt, 1);

    // Signed values: the first pooled row is -3, -1
    rand_plane();
    pl[0] = -16'sd3; pl[1] = -16'sd7; pl[2] = -16'sd1; pl[3] = -16'sd2;
    pl[4] = -16'sd5; pl[5] = -16'sd4; pl[6] = -16'sd8; pl[7] = -16'sd9;
    expect_plane();
    send_beats(0, 6, N-1);
    check("signed_first", 32'(out_data), 32'(16'hfffd));
    send_beats(6, 8, N-1);
    check("signed_second", 32'(out_data), 32'(16'hffff));
    send_beats(8, N, N-1);
    drain();

    // Backpressure: stall after the first pooled output
    rand_plane();
    expect_plane();
    rdy_cmd = 1'b0;
    send_beats(0, 6, N-1);
    check("bp_in_ready", {31'b0, in_ready}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_data", 32'(out_data), 32'(pool(0, 0)));
      check("bp_hold_valid", {31'b0, out_valid}, 1);
      check("bp_in_ready_hold", {31'b0, in_ready}, 0);
    end
    @(posedge clk); #1;
    rdy_cmd = 1'b1;
    send_beats(6, N, N-1);
    drain();

    // Random out_ready over 3 planes
    rand_mode = 1'b1;
    for (int p = 0; p < 3; p++) begin
      rand_plane();
      expect_plane();
      send_beats(0, N, N-1);
    end
    drain();
    rand_mode = 1'b0;

    // Two back-to-back planes: two out_last pulses, no error
    last_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      rand_plane();
      expect_plane();
      send_beats(0, N, N-1);
    end
    drain();
    check("wrap_last_cnt", last_cnt, 2);
    check("wrap_err_last", {31'b0, err_last}, 0);

    // in_last on pixel 10 sets the sticky error
    rand_plane();
    expect_plane();
    send_beats(0, N, 10);
    drain();
    check("err_set", {31'b0, err_last}, 1);
    rand_plane();
    expect_plane();
    send_beats(0, N, N-1);
    drain();
    check("err_sticky", {31'b0, err_last}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("err_cleared", {31'b0, err_last}, 0);

    // Reset mid-plane drops the pending output
    rand_plane();
    rdy_cmd = 1'b0;
    for (int i = 0; i < 6; i++) send(pl[i], 1'b0);
    check("mid_pending", {31'b0, out_valid}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_dropped", {31'b0, out_valid}, 0);
    rdy_cmd = 1'b1;
    rand_plane();
    expect_plane();
    send_beats(0, N, N-1);
    drain();
    check("mid_err_last", {31'b0, err_last}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
